fft_n_rad2: RTL and testbench

Radix-2 N-point FFT engine for the MIMO-OFDM receive path. It captures two parallel complex sample streams (antenna 0 and antenna 1), one sample per stream per enabled clock. On each completed frame of N samples, it computes the DFT of each stream in turn using one shared bank of N/2 butterflies, one stage per clock. It presents each N-bin result on a parallel output array, tagged by `output_mode`.

---
 rtl/fft_n_rad2.sv | 166 ++++++++++++++++
 tb/tb_fft_n_rad2.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_n_rad2.sv
// Two-stream radix-2 DIT FFT: bit-reversed capture, then one butterfly stage per clock on a shared N/2 bank.
// Optional macro FFT_STAGE_SCALE_EN halves every butterfly output (overall 1/N scaling).
module fft_n_rad2 #(
  parameter int N  = 128,
  parameter int DW = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [2*DW-1:0]        data_in_0,
  input  logic [2*DW-1:0]        data_in_1,
  output logic [N-1:0][2*DW-1:0] fft_out,
  output logic                   output_mode,
  output logic                   out_valid
);
  localparam int  L  = $clog2(N);
  localparam int  H  = N / 2;
  localparam int  SW = $clog2(L);
  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {IDLE, C0, C1} state_t;

  state_t          r_state, w_state_next;
  logic [L-1:0]    r_cnt;
  logic            r_snap_pend;
  logic [SW-1:0]   r_stage;
  logic [2*DW-1:0] r_buf0 [N];
  logic [2*DW-1:0] r_buf1 [N];
  logic [2*DW-1:0] r_work [N];
  logic [2*DW-1:0] r_hold [N];
  logic [2*DW-1:0] w_work_next [N];
  logic            w_last;
  logic [SW-1:0]   w_shamt;

  function automatic logic [L-1:0] f_bitrev(input logic [L-1:0] v);
    logic [L-1:0] r;
    for (int b = 0; b < L; b++) r[b] = v[L-1-b];
    return r;
  endfunction

  function automatic logic signed [15:0] f_round(input real x);
    int v;
    v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    return 16'(v);
  endfunction

  // Twiddle W_N^k = cos - j*sin, stored directly as (re, im) in Q1.15
  logic signed [15:0] w_tw_re [H];
  logic signed [15:0] w_tw_im [H];
  generate
    for (genvar gi = 0; gi < H; gi++) begin : g_tw
      assign w_tw_re[gi] = f_round(32767.0 * $cos(2.0 * PI * real'(gi) / real'(N)));
      assign w_tw_im[gi] = -f_round(32767.0 * $sin(2.0 * PI * real'(gi) / real'(N)));
    end
  endgenerate

  assign w_last  = (r_stage == SW'(L - 1));
  assign w_shamt = SW'(L - 1) - r_stage;

  logic [L-1:0]          w_b, w_h, w_j, w_p, w_q;
  logic [L-2:0]          w_t;
  logic signed [15:0]    w_wr, w_wi;
  logic signed [DW-1:0]  w_ar, w_ai, w_br, w_bi, w_mr, w_mi, w_sr, w_si, w_dr, w_di;
  logic signed [DW+16:0] w_pr, w_pi;

  always_comb begin
    w_work_next = r_work;
    w_b = '0; w_h = '0; w_j = '0; w_p = '0; w_q = '0; w_t = '0;
    w_wr = '0; w_wi = '0; w_pr = '0; w_pi = '0;
    w_ar = '0; w_ai = '0; w_br = '0; w_bi = '0; w_mr = '0; w_mi = '0;
    w_sr = '0; w_si = '0; w_dr = '0; w_di = '0;
    for (int bi = 0; bi < H; bi++) begin
      w_b = L'(bi);
      w_h = L'(1) << r_stage;
      w_j = w_b & (w_h - L'(1));
      w_p = (((w_b >> r_stage) << r_stage) << 1) | w_j;
      w_q = w_p | w_h;
      w_t = (L-1)'(w_j << w_shamt);
      w_ar = r_work[w_p][2*DW-1:DW];
      w_ai = r_work[w_p][DW-1:0];
      w_br = r_work[w_q][2*DW-1:DW];
      w_bi = r_work[w_q][DW-1:0];
      w_wr = w_tw_re[w_t];
      w_wi = w_tw_im[w_t];
      w_pr = (DW+17)'(w_wr) * (DW+17)'(w_br) - (DW+17)'(w_wi) * (DW+17)'(w_bi);
      w_pi = (DW+17)'(w_wr) * (DW+17)'(w_bi) + (DW+17)'(w_wi) * (DW+17)'(w_br);
      w_mr = w_pr[15 +: DW];
      w_mi = w_pi[15 +: DW];
      w_sr = w_ar + w_mr;
      w_si = w_ai + w_mi;
      w_dr = w_ar - w_mr;
      w_di = w_ai - w_mi;
`ifdef FFT_STAGE_SCALE_EN
      w_sr = w_sr >>> 1;
      w_si = w_si >>> 1;
      w_dr = w_dr >>> 1;
      w_di = w_di >>> 1;
`else
`endif
      w_work_next[w_p] = {w_sr, w_si};
      w_work_next[w_q] = {w_dr, w_di};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_snap_pend <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_buf0[i] <= '0;
        r_buf1[i] <= '0;
      end
    end else begin
      r_snap_pend <= enable && (r_cnt == L'(N - 1));
      if (enable) begin
        r_buf0[f_bitrev(r_cnt)] <= data_in_0;
        r_buf1[f_bitrev(r_cnt)] <= data_in_1;
        r_cnt <= r_cnt + L'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (r_snap_pend) w_state_next = C0;
      C0:      if (w_last) w_state_next = C1;
      C1:      if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Stream 1 waits in r_hold while stream 0 occupies the butterfly bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_stage     <= '0;
      fft_out     <= '0;
      output_mode <= 1'b0;
      out_valid   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_work[i] <= '0;
        r_hold[i] <= '0;
      end
    end else begin
      r_state   <= w_state_next;
      out_valid <= 1'b0;
      if (r_snap_pend) begin
        r_work  <= r_buf0;
        r_hold  <= r_buf1;
        r_stage <= '0;
      end else if (r_state != IDLE) begin
        if (w_last) begin
          for (int k = 0; k < N; k++) fft_out[k] <= w_work_next[k];
          output_mode <= (r_state == C1);
          out_valid   <= 1'b1;
          r_stage     <= '0;
          r_work      <= r_hold;
        end else begin
          r_stage <= r_stage + SW'(1);
          r_work  <= w_work_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_n_rad2.sv
// Directed bench for fft_n_rad2 (N=128): impulse, DC, tone, back-to-back, enable gap, resets.
module tb_fft_n_rad2;
  localparam int  N  = 128;
  localparam int  L  = 7;
  localparam real PI = 3.14159265358979323846;
  localparam int  K_ZERO = 0, K_IMP0 = 1, K_IMP1 = 2, K_DC = 3, K_TONE = 4;

  typedef logic [N-1:0][63:0] bins_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [63:0] data_in_0, data_in_1;
  bins_t       fft_out;
  logic        output_mode, out_valid;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int e1, e2, e3;

  int    ev_cyc[$];
  bit    ev_mode[$];
  bins_t ev_data[$];

  fft_n_rad2 #(.N(N), .DW(32)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .data_in_0(data_in_0), .data_in_1(data_in_1),
    .fft_out(fft_out), .output_mode(output_mode), .out_valid(out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_mode.push_back(output_mode);
      ev_data.push_back(fft_out);
      $display("result edge=%0d mode=%0d bin0_re=%0d bin1_re=%0d", cyc, output_mode,
               $signed(fft_out[0][63:32]), $signed(fft_out[1][63:32]));
    end
  end

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    return -longint'($rtoi(0.5 - x));
  endfunction

  function automatic longint tw_c(input int j);
    return rnd(32767.0 * $cos(2.0 * PI * real'(j) / real'(N)));
  endfunction

  function automatic longint tw_s(input int j);
    return -rnd(32767.0 * $sin(2.0 * PI * real'(j) / real'(N)));
  endfunction

  function automatic longint fre(input logic [63:0] v);
    return longint'($signed(v[63:32]));
  endfunction

  function automatic longint fim(input logic [63:0] v);
    return longint'($signed(v[31:0]));
  endfunction

  function automatic logic [63:0] smp(input int kind, input int amp, input int n);
    logic [63:0] v;
    v = '0;
    case (kind)
      K_IMP0: if (n == 0) v = {32'(amp), 32'd0};
      K_IMP1: if (n == 1) v = {32'(amp), 32'd0};
      K_DC:   v = {32'(amp), 32'd0};
      K_TONE: v = {32'(rnd(real'(amp) * $cos(2.0 * PI * real'(n) / real'(N)))),
                   32'(rnd(real'(amp) * $sin(2.0 * PI * real'(n) / real'(N))))};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic bins_t get_ev(input int idx);
    if (idx < ev_data.size()) return ev_data[idx];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input longint obs, input longint exp, input longint tol);
    n_total++;
    assert (((obs >= exp - tol) && (obs <= exp + tol)) === 1'b1) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic chk_imp0(input string tag, input bins_t b, input longint amp);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_re[%0d]", tag, k), fre(b[k]), amp);
      chk($sformatf("%s_im[%0d]", tag, k), fim(b[k]), 0);
    end
  endtask

  // Impulse at n=1: X[k] = W^k*A; the lower half is +W*b, the upper half is -(W*b)
  task automatic chk_imp1(input string tag, input bins_t b, input longint amp);
    longint mr, mi;
    for (int k = 0; k < N; k++) begin
      mr = (tw_c(k % (N/2)) * amp) >>> 15;
      mi = (tw_s(k % (N/2)) * amp) >>> 15;
      if (k >= N/2) begin
        mr = -mr;
        mi = -mi;
      end
      chk($sformatf("%s_re[%0d]", tag, k), fre(b[k]), mr);
      chk($sformatf("%s_im[%0d]", tag, k), fim(b[k]), mi);
    end
  endtask

  // DC 100: W^0 = 32767/32768 truncates, so each stage gives v + (v-1): 199,397,...,12673
  task automatic chk_dc(input string tag, input bins_t b);
    chk($sformatf("%s_re[0]", tag), fre(b[0]), 12673);
    chk($sformatf("%s_im[0]", tag), fim(b[0]), 0);
    for (int k = 1; k < N; k++) begin
      chk_near($sformatf("%s_re[%0d]", tag, k), fre(b[k]), 0, N);
      chk_near($sformatf("%s_im[%0d]", tag, k), fim(b[k]), 0, N);
    end
  endtask

  task automatic chk_tone(input string tag, input bins_t b);
    int bl[4] = '{0, 2, 64, 127};
    chk_near($sformatf("%s_re[1]", tag), fre(b[1]), 128000, N);
    chk_near($sformatf("%s_im[1]", tag), fim(b[1]), 0, N);
    foreach (bl[i]) begin
      chk_near($sformatf("%s_re[%0d]", tag, bl[i]), fre(b[bl[i]]), 0, N);
      chk_near($sformatf("%s_im[%0d]", tag, bl[i]), fim(b[bl[i]]), 0, N);
    end
  endtask

  task automatic chk_pair(input string tag, input int idx, input int e);
    if (ev_cyc.size() >= idx + 2) begin
      chk({tag, "_t0"}, ev_cyc[idx], e + 1 + L);
      chk({tag, "_m0"}, ev_mode[idx], 0);
      chk({tag, "_t1"}, ev_cyc[idx+1], e + 1 + 2*L);
      chk({tag, "_m1"}, ev_mode[idx+1], 1);
    end else begin
      chk({tag, "_present"}, ev_cyc.size(), idx + 2);
    end
  endtask

  task automatic ev_clear();
    ev_cyc.delete();
    ev_mode.delete();
    ev_data.delete();
  endtask

  task automatic feed(input int k0, input int a0, input int k1, input int a1,
                      input int gap, input int nsamp, output int e);
    e = 0;
    for (int n = 0; n < nsamp; n++) begin
      @(negedge clk);
      if (n == gap) begin
        enable = 1'b0;
        repeat (5) @(negedge clk);
      end
      enable    = 1'b1;
      data_in_0 = smp(k0, a0, n);
      data_in_1 = smp(k1, a1, n);
      e = cyc + 1;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; data_in_0 = '0; data_in_1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_mode", output_mode, 0);
    chk("rst_fft_zero", (fft_out === '0), 1);
    reset = 1'b0;

    // Single frame: impulse on stream 0, DC on stream 1
    ev_clear();
    feed(K_IMP0, 1000, K_DC, 100, -1, N, e1);
    @(negedge clk); enable = 1'b0;
    repeat (2*L + 6) @(negedge clk);
    chk("s1_nev", ev_cyc.size(), 2);
    chk_pair("s1", 0, e1);
    chk_imp0("s1_imp", get_ev(0), 1000);
    chk_dc("s1_dc", get_ev(1));
    chk("s1_hold", (fft_out === get_ev(1)), 1);
    chk("s1_hold_mode", output_mode, 1);
    chk("s1_valid_low", out_valid, 0);

    // Three back-to-back frames, enable held high
    ev_clear();
    feed(K_TONE, 1000, K_IMP0, 1000, -1, N, e1);
    feed(K_IMP1, 1000, K_DC, 100, -1, N, e2);
    feed(K_IMP0, 2000, K_IMP0, 300, -1, N, e3);
    @(negedge clk); enable = 1'b0;
    repeat (2*L + 6) @(negedge clk);
    chk("b2b_nev", ev_cyc.size(), 6);
    chk_pair("b2b_f1", 0, e1);
    chk_pair("b2b_f2", 2, e2);
    chk_pair("b2b_f3", 4, e3);
    chk_tone("b2b_tone", get_ev(0));
    chk_imp0("b2b_f1s1", get_ev(1), 1000);
    chk_imp1("b2b_f2s0", get_ev(2), 1000);
    chk_dc("b2b_f2s1", get_ev(3));
    chk_imp0("b2b_f3s0", get_ev(4), 2000);
    chk_imp0("b2b_f3s1", get_ev(5), 300);

    // Five-cycle enable gap mid-frame
    ev_clear();
    feed(K_IMP1, 1000, K_IMP0, 700, 40, N, e1);
    @(negedge clk); enable = 1'b0;
    repeat (2*L + 6) @(negedge clk);
    chk("gap_nev", ev_cyc.size(), 2);
    chk_pair("gap", 0, e1);
    chk_imp1("gap_s0", get_ev(0), 1000);
    chk_imp0("gap_s1", get_ev(1), 700);

    // Reset during computation discards the result in progress
    ev_clear();
    feed(K_DC, 100, K_DC, 100, -1, N, e1);
    @(negedge clk); enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rc_valid", out_valid, 0);
    chk("rc_fft_zero", (fft_out === '0), 1);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("rc_nev", ev_cyc.size(), 0);

    // Reset at cnt=60, then a fresh frame
    ev_clear();
    feed(K_DC, 500, K_DC, 500, -1, 60, e1);
    @(negedge clk); enable = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("r60_valid", out_valid, 0);
    chk("r60_mode", output_mode, 0);
    chk("r60_fft_zero", (fft_out === '0), 1);
    reset = 1'b0;
    feed(K_IMP0, 1000, K_ZERO, 0, -1, N, e2);
    @(negedge clk); enable = 1'b0;
    repeat (2*L + 6) @(negedge clk);
    chk("r60_nev", ev_cyc.size(), 2);
    chk_pair("r60", 0, e2);
    chk_imp0("r60_s0", get_ev(0), 1000);
    chk_imp0("r60_s1", get_ev(1), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
